// File: rtl/alu_acc_stack_pkg.sv
// Shared opcode encodings and default sizes for the accumulator ALU.
package alu_acc_stack_pkg;

    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefStackDepth = 4;

    typedef enum logic [3:0] {
        OpLd     = 4'h0,
        OpLdn    = 4'h1,
        OpAnd    = 4'h2,
        OpOr     = 4'h3,
        OpXor    = 4'h4,
        OpNot    = 4'h5,
        OpSt     = 4'h6,
        OpStn    = 4'h7,
        OpAdd    = 4'h8,
        OpSub    = 4'h9,
        OpPush   = 4'hA,
        OpPopAnd = 4'hB,
        OpPopOr  = 4'hC,
        OpShl    = 4'hD,
        OpShr    = 4'hE,
        OpNop    = 4'hF
    } alu_op_e;

endpackage

// File: rtl/alu_stack.sv
// Pointer-based LIFO of saved accumulator values; overflow/underflow requests are ignored.
module alu_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    // Only meaningful when not empty; callers gate on empty.
    assign top   = mem_q[IdxW'(count_q - CntW'(1))];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[IdxW'(count_q)] <= din;
            count_q               <= count_q + CntW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CntW'(1);
        end
    end

endmodule

// File: rtl/alu_acc_stack.sv
// Multi-bit accumulator ALU with zero/carry flags, iterative shifter and a LIFO
// of saved accumulator values for nested logic expressions.
module alu_acc_stack
    import alu_acc_stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned STACK_DEPTH = DefStackDepth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  err_flag
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [ShW-1:0]        cnt_q, cnt_d;
    logic                  shl_q, shl_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  carry_q, carry_d;
    logic                  err_q, err_d;
    logic                  ov_q, ov_d;

    alu_op_e               op;
    logic                  accept;
    logic [ShW-1:0]        shamt;
    logic [DATA_WIDTH:0]   sum, diff;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] top;

    assign op       = alu_op_e'(alu_op);
    assign op_ready = (state_q == StIdle);
    assign accept   = op_valid && op_ready;
    assign shamt    = data_in[ShW-1:0];
    assign sum      = {1'b0, acc_q} + {1'b0, data_in};
    // Top bit of the widened difference is the borrow.
    assign diff     = {1'b0, acc_q} - {1'b0, data_in};

    alu_stack #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (acc_q),
        .top  (top),
        .empty(stack_empty),
        .full (stack_full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shl_d   = shl_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        carry_d = carry_q;
        err_d   = err_q;
        ov_d    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op)
                        OpLd:  acc_d = data_in;
                        OpLdn: acc_d = ~data_in;
                        OpAnd: acc_d = acc_q & data_in;
                        OpOr:  acc_d = acc_q | data_in;
                        OpXor: acc_d = acc_q ^ data_in;
                        OpNot: acc_d = ~acc_q;
                        OpSt: begin
                            dout_d = acc_q;
                            ov_d   = 1'b1;
                        end
                        OpStn: begin
                            dout_d = ~acc_q;
                            ov_d   = 1'b1;
                        end
                        OpAdd: begin
                            acc_d   = sum[DATA_WIDTH-1:0];
                            carry_d = sum[DATA_WIDTH];
                        end
                        OpSub: begin
                            acc_d   = diff[DATA_WIDTH-1:0];
                            carry_d = diff[DATA_WIDTH];
                        end
                        OpPush: begin
                            push = 1'b1;
                            if (stack_full) err_d = 1'b1;
                        end
                        OpPopAnd, OpPopOr: begin
                            if (stack_empty) begin
                                err_d = 1'b1;
                            end else begin
                                pop   = 1'b1;
                                acc_d = (op == OpPopAnd) ? (top & acc_q) : (top | acc_q);
                            end
                        end
                        OpShl, OpShr: begin
                            if (shamt != '0) begin
                                state_d = StShift;
                                cnt_d   = shamt;
                                shl_d   = (op == OpShl);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StShift: begin
                if (shl_q) begin
                    carry_d = acc_q[DATA_WIDTH-1];
                    acc_d   = {acc_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    carry_d = acc_q[0];
                    acc_d   = {1'b0, acc_q[DATA_WIDTH-1:1]};
                end
                cnt_d = cnt_q - ShW'(1);
                if (cnt_q == ShW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shl_q   <= 1'b0;
            acc_q   <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shl_q   <= shl_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
        end
    end

    assign acc        = acc_q;
    assign zero_flag  = (acc_q == '0);
    assign carry_flag = carry_q;
    assign err_flag   = err_q;
    assign data_out   = dout_q;
    assign out_valid  = ov_q;

endmodule
